// File: rtl/shift_window_ctrl.sv
// shift_window_ctrl
//   Fetches a WxH frame of pixel words from memory in raster order (one word
//   per read handshake) and pushes each word into the line-buffer / 3x3 window
//   shift chain. It tracks row/col of every shifted word and flags when the
//   3x3 window around (row-1, col-1) is fully populated.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      begin a frame (sampled in IDLE only)
//   base_addr, img_width,      frame geometry, latched on an accepted start
//   img_height
//   rd_req, rd_addr            memory read request / word address
//   rd_ack, rd_data            read accepted, data valid in the same cycle
//   shift_en, shift_data       one-cycle push into the shift chain
//   window_valid, win_row,     3x3 window complete, centre coordinates
//   win_col
//   busy, done, err            frame in progress, end-of-frame pulse,
//                              sticky rejected-frame flag
//   stall                      (only with SHIFT_WINDOW_CTRL_STALL_EN) pauses
//                              read requests while in FETCH
//
// Configuration macro: SHIFT_WINDOW_CTRL_STALL_EN
//   Undefined (default): no stall port, behaves as stall=0.
//
// All outputs are registered.
module shift_window_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              shift_en,
  output logic [DATA_W-1:0] shift_data,
  output logic              window_valid,
  output logic [DIM_W-1:0]  win_row,
  output logic [DIM_W-1:0]  win_col,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
  ,
  input  logic              stall
`endif
);

  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LAST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              shift_en_q, shift_en_d;
  logic [DATA_W-1:0] shift_data_q, shift_data_d;
  logic              window_valid_q, window_valid_d;
  logic [DIM_W-1:0]  win_row_q, win_row_d;
  logic [DIM_W-1:0]  win_col_q, win_col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              stall_s;
  logic              ack_s;

`ifdef SHIFT_WINDOW_CTRL_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  // An ack only counts while our own registered request is up.
  assign ack_s = (state_q == S_FETCH) && rd_req_q && rd_ack;

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    width_d        = width_q;
    total_d        = total_q;
    idx_d          = idx_q;
    row_d          = row_q;
    col_d          = col_q;
    rd_req_d       = 1'b0;
    rd_addr_d      = rd_addr_q;
    shift_en_d     = 1'b0;
    shift_data_d   = shift_data_q;
    window_valid_d = 1'b0;
    win_row_d      = win_row_q;
    win_col_d      = win_col_q;
    done_d         = 1'b0;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          width_d = img_width;
          total_d = CNT_W'(img_width) * CNT_W'(img_height);
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          if ((img_width < DIM_W'(3)) || (img_height < DIM_W'(3))) begin
            // Rejected frames pass through the LAST slot (with no shift) so
            // that done lands two cycles after start.
            err_d   = 1'b1;
            state_d = S_LAST;
          end else begin
            err_d     = 1'b0;
            state_d   = S_FETCH;
            rd_req_d  = 1'b1;
            rd_addr_d = base_addr;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        if (ack_s) begin
          shift_en_d     = 1'b1;
          shift_data_d   = rd_data;
          window_valid_d = (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
          if ((row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2))) begin
            win_row_d = row_q - DIM_W'(1);
            win_col_d = col_q - DIM_W'(1);
          end else begin
            win_row_d = win_row_q;
            win_col_d = win_col_q;
          end
          // row/col advance to the position of the next word to be fetched.
          if (col_q == width_q - DIM_W'(1)) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (idx_q == total_q - CNT_W'(1)) begin
            state_d  = S_LAST;
            rd_req_d = 1'b0;
          end else begin
            idx_d     = idx_q + CNT_W'(1);
            rd_addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
            rd_req_d  = !stall_s;
          end
        end else begin
          // Address is held while waiting for (or stalling) the ack.
          rd_req_d = !stall_s;
        end
      end

      S_LAST: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      width_q        <= '0;
      total_q        <= '0;
      idx_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= '0;
      shift_en_q     <= 1'b0;
      shift_data_q   <= '0;
      window_valid_q <= 1'b0;
      win_row_q      <= '0;
      win_col_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      width_q        <= width_d;
      total_q        <= total_d;
      idx_q          <= idx_d;
      row_q          <= row_d;
      col_q          <= col_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      shift_en_q     <= shift_en_d;
      shift_data_q   <= shift_data_d;
      window_valid_q <= window_valid_d;
      win_row_q      <= win_row_d;
      win_col_q      <= win_col_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign shift_en     = shift_en_q;
  assign shift_data   = shift_data_q;
  assign window_valid = window_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Self-checking bench for shift_window_ctrl: a table of frames plus random
// frames, each checked word-by-word against a raster-order reference model,
// and a hand-written reset-mid-frame sequence.
module tb_shift_window_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, rd_req, rd_ack, shift_en, window_valid, busy, done, err;
  logic [ADDR_W-1:0] base_addr, rd_addr;
  logic [DIM_W-1:0]  img_width, img_height, win_row, win_col;
  logic [DATA_W-1:0] rd_data, shift_data;
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
  logic stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  shift_window_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .img_width(img_width), .img_height(img_height), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .shift_en(shift_en), .shift_data(shift_data), .window_valid(window_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done), .err(err)
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
    , .stall(stall)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content: unique word per address.
  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  assign rd_data = pix(rd_addr);

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    int w;
    int h;
    int mode;       // 0 ack always, 1 ack every 3rd request, 2 random, 3 stall
    int exp_shifts;
    int exp_wins;
  } vec_t;

  vec_t vecs[$];

  // Runs one frame; checks every request address and every shifted word
  // against the raster-order model, plus done/err/busy timing.
  task automatic run_frame(input logic [ADDR_W-1:0] b, input int w, input int h,
                           input int mode, output int n_sh, output int n_win);
    int  acks, start_cyc, last_sh, done_cyc, gap, budget, total, r, c, stall_left;
    bit  req_seen, bad, wv, prev_stall;
    acks = 0; last_sh = -100; done_cyc = -1; gap = 0; req_seen = 1'b0;
    stall_left = 4; prev_stall = 1'b0;
    bad   = (w < 3) || (h < 3);
    total = w * h;
    n_sh  = 0;
    n_win = 0;
    budget = 60 + 8 * total;
    @(negedge clk);
    base_addr = b; img_width = DIM_W'(w); img_height = DIM_W'(h);
    start = 1'b1; rd_ack = 1'b0; start_cyc = cyc;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      start = 1'b0; rd_ack = 1'b0;
      if (t == 0) begin
        check("rd_req_after_start", rd_req, !bad);
        check("busy_after_start", busy, 1);
        check("err_on_start", err, bad);
      end
      if (rd_req) begin
        req_seen = 1'b1;
        check("rd_addr", rd_addr, ADDR_W'(b + acks));
      end
      if (prev_stall) check("rd_req_in_stall", rd_req, 0);
      if (shift_en) begin
        if (n_sh < total) begin
          r  = n_sh / w;
          c  = n_sh % w;
          wv = (r >= 2) && (c >= 2);
          check("shift_data", shift_data, pix(ADDR_W'(b + n_sh)));
          check("window_valid", window_valid, wv);
          if (wv) begin
            check("win_row", win_row, r - 1);
            check("win_col", win_col, c - 1);
            n_win++;
          end
        end
        n_sh++;
        last_sh = cyc;
      end else begin
        check("window_valid_without_shift", window_valid, 0);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      prev_stall = 1'b0;
      case (mode)
        0: rd_ack = rd_req;
        1: begin
          if (rd_req) gap++;
          rd_ack = rd_req && (gap % 3 == 0);
        end
        2: begin
          rd_ack = 1'($urandom_range(0, 1));
          if (busy && ($urandom_range(0, 3) == 0)) begin
            start = 1'b1;
            base_addr = ADDR_W'($urandom);
            img_width = DIM_W'($urandom_range(0, 9));
            img_height = DIM_W'($urandom_range(0, 9));
          end
        end
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
        3: begin
          stall = 1'b0;
          if (acks >= 6 && stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
            prev_stall = 1'b1;
          end
          rd_ack = rd_req;
        end
`endif
        default: rd_ack = rd_req;
      endcase
      if (rd_req && rd_ack) acks++;
    end
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
    stall = 1'b0;
`endif
    rd_ack = 1'b0;
    check("done_seen", done_cyc >= 0, 1);
    check("err_at_done", err, bad);
    check("busy_in_done", busy, 1);
    if (bad) begin
      check("done_after_start", done_cyc - start_cyc, 2);
      check("rd_req_never", req_seen, 0);
    end else begin
      check("done_after_last_shift", done_cyc - last_sh, 1);
    end
    // start during DONE must be ignored.
    base_addr = 16'h0000; img_width = 10'd5; img_height = 10'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", rd_req, 0);
    check("err_sticky", err, bad);
  endtask

  initial begin
    int n_sh, n_win, w, h, acks, quiet;
    rst_n = 1'b0; start = 1'b0; rd_ack = 1'b0;
    base_addr = '0; img_width = '0; img_height = '0;
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
    stall = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_rd_req", rd_req, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_shift_en", shift_en, 0);
    check("reset_shift_data", shift_data, 0);
    check("reset_window", {window_valid, win_row, win_col}, 0);
    check("reset_status", {busy, done, err}, 0);
    rst_n = 1'b1;

    vecs.push_back('{16'h0100, 4, 3, 0, 12, 2});
    vecs.push_back('{16'h0100, 4, 3, 1, 12, 2});
    vecs.push_back('{16'h0100, 2, 5, 0, 0, 0});
    vecs.push_back('{16'hFFFE, 3, 3, 0, 9, 1});
    vecs.push_back('{16'h1234, 5, 4, 2, 20, 6});
    vecs.push_back('{16'h0000, 3, 2, 0, 0, 0});
    vecs.push_back('{16'h8000, 6, 5, 1, 30, 12});
`ifdef SHIFT_WINDOW_CTRL_STALL_EN
    vecs.push_back('{16'h0100, 4, 3, 3, 12, 2});
`endif

    foreach (vecs[i]) begin
      run_frame(vecs[i].base, vecs[i].w, vecs[i].h, vecs[i].mode, n_sh, n_win);
      check("table_shift_count", n_sh, vecs[i].exp_shifts);
      check("table_window_count", n_win, vecs[i].exp_wins);
    end

    // Random frames against the model.
    for (int k = 0; k < 12; k++) begin
      w = $urandom_range(1, 7);
      h = $urandom_range(1, 7);
      run_frame(ADDR_W'($urandom), w, h, $urandom_range(0, 2), n_sh, n_win);
      check("rand_shift_count", n_sh, ((w < 3) || (h < 3)) ? 0 : w * h);
      check("rand_window_count", n_win, ((w < 3) || (h < 3)) ? 0 : (w - 2) * (h - 2));
    end

    // Reset for one cycle right after the 5th ack has been taken.
    @(negedge clk);
    base_addr = 16'h0100; img_width = 10'd4; img_height = 10'd3; start = 1'b1;
    acks = 0;
    for (int t = 0; t < 40 && acks < 5; t++) begin
      @(negedge clk);
      start = 1'b0;
      rd_ack = rd_req;
      if (rd_req) acks++;
    end
    check("rst_seq_acks", acks, 5);
    @(negedge clk);
    rd_ack = 1'b0;
    check("rst_seq_5th_shift", shift_en, 1);
    check("rst_seq_5th_data", shift_data, pix(16'h0104));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_seq_busy", busy, 0);
    check("rst_seq_outputs", {rd_req, shift_en, done, err}, 0);
    check("rst_seq_rd_addr", rd_addr, 0);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (shift_en || done || rd_req || busy) quiet++;
    end
    check("rst_seq_quiet", quiet, 0);
    run_frame(16'h0100, 4, 3, 0, n_sh, n_win);
    check("rst_seq_restart_shifts", n_sh, 12);
    check("rst_seq_restart_windows", n_win, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
